sync_fifo_flags: RTL

Parametrised synchronous FIFO with an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and defined simultaneous read/write behaviour at the full and empty boundaries. It replaces the fixed 16x8 FIFO used in datapath buffering between single-clock producer and consumer stages. All state is in one clock domain.

---
 rtl/sync_fifo_pkg.sv | 32 +++
 rtl/sync_fifo_mem.sv | 68 ++++++
 rtl/sync_fifo_flags.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Purpose  : Shared defaults and an elaboration-time log2 helper for the
//            sync_fifo_flags FIFO and its storage sub-module.
// Contents : DEF_WIDTH, DEF_DEPTH, DEF_PTR_WIDTH, DEF_AF_LEVEL,
//            DEF_AE_LEVEL, clog2()
// Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_PTR_WIDTH = 4;
  localparam int DEF_AF_LEVEL  = 14;
  localparam int DEF_AE_LEVEL  = 2;

  // Ceiling log2 for parameter checks. The loop stops at bit 30 so the shift
  // never reaches the sign bit of a 32-bit int.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_mem
// Purpose  : DEPTH x WIDTH storage array with one write port and one read
//            port for the sync_fifo_flags FIFO.
// Macro    : SYNC_FIFO_FWFT_EN - when defined the read port is combinational
//            (first-word-fall-through); otherwise it is a registered read
//            that updates only when rd_en_i is high and resets to zero.
// Ports    : clk_i      - clock, rising edge
//            rst_i      - synchronous active-high reset (read register only)
//            wr_en_i    - write strobe (already qualified by the controller)
//            wr_addr_i  - write address
//            wdata_i    - write data
//            rd_en_i    - read strobe (already qualified by the controller)
//            rd_addr_i  - read address
//            rdata_o    - read data
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [PTR_WIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  input  logic [PTR_WIDTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  // Array contents are intentionally not reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wdata_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head of queue is always presented; the pop only advances the pointer in
  // the controller, so reset and the read strobe have no role here.
  assign rdata_o = mem_q[rd_addr_i];

  logic unused_fwft;
  assign unused_fwft = &{1'b0, rst_i, rd_en_i};
`else
  // Registered read. When the FIFO is full and a write lands on the same
  // address being read, the non-blocking update guarantees the old (oldest)
  // entry is captured rather than the incoming word.
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[rd_addr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags
// Purpose  : Parametrised single-clock FIFO with explicit occupancy count,
//            registered full/empty and almost-full/almost-empty flags,
//            synchronous flush and one-cycle error pulses on rejected
//            requests.
// Macro    : SYNC_FIFO_FWFT_EN - first-word-fall-through read port
//            (rdata_o valid whenever empty_o is low, rd_en_i pops).
//            Undefined: rdata_o is registered and valid one cycle after an
//            accepted read, holding otherwise.
// Ports    : clk_i          - clock, rising edge
//            rst_i          - synchronous active-high reset
//            flush_i        - synchronous clear of pointers/count/flags
//            wr_en_i        - write request
//            wdata_i        - write data
//            rd_en_i        - read request
//            rdata_o        - read data
//            full_o         - count == DEPTH
//            empty_o        - count == 0
//            almost_full_o  - count >= AF_LEVEL
//            almost_empty_o - count <= AE_LEVEL
//            count_o        - number of stored entries, 0..DEPTH
//            wr_error_o     - one-cycle pulse after a rejected write
//            rd_error_o     - one-cycle pulse after a rejected read
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int AF_LEVEL  = DEF_AF_LEVEL,
  parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               rd_en_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               almost_full_o,
  output logic               almost_empty_o,
  output logic [PTR_WIDTH:0] count_o,
  output logic               wr_error_o,
  output logic               rd_error_o
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: WIDTH must be at least 1");
  end

  if (DEPTH < 2 || DEPTH != (1 << PTR_WIDTH) || PTR_WIDTH != clog2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2 equal to 2**PTR_WIDTH");
  end

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_LEVEL out of range 1..DEPTH");
  end

  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_LEVEL out of range 0..DEPTH-1");
  end

  // Thresholds expressed at count width so all compares are same-width.
  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_CNT    = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_CNT    = (PTR_WIDTH+1)'(AE_LEVEL);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   count_q,  count_d;
  logic                 full_q,   full_d;
  logic                 empty_q,  empty_d;
  logic                 afull_q,  afull_d;
  logic                 aempty_q, aempty_d;
  logic                 wr_err_q, wr_err_d;
  logic                 rd_err_q, rd_err_d;

  logic                 wr_accept;
  logic                 rd_accept;

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  // The read is judged on the registered empty flag only, so a write into an
  // empty FIFO never makes a same-cycle read acceptable. A write into a full
  // FIFO is acceptable only when the read frees a slot in the same cycle.
  // Flush swallows both requests without raising an error.
  always_comb begin
    rd_accept = rd_en_i && !empty_q && !flush_i;
    wr_accept = wr_en_i && (!full_q || rd_accept) && !flush_i;
  end

  // --------------------------------------------------------------------------
  // Next-state: pointers, count, flags, error pulses
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_err_d = 1'b0;
    rd_err_d = 1'b0;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end

      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase

      wr_err_d = wr_en_i && !wr_accept;
      rd_err_d = rd_en_i && !rd_accept;
    end

    // Flags follow the next-state count so they line up with the pointers
    // in the same cycle. A zero count reproduces the reset flag values,
    // which is what makes flush need no special flag handling.
    full_d   = (count_d == DEPTH_CNT);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_CNT);
    aempty_d = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  sync_fifo_mem #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q),
    .wdata_i   (wdata_i),
    .rd_en_i   (rd_accept),
    .rd_addr_i (rd_ptr_q),
    .rdata_o   (rdata_o)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;
  assign wr_error_o     = wr_err_q;
  assign rd_error_o     = rd_err_q;

endmodule : sync_fifo_flags
`default_nettype wire
